dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the CPU load/store stage (port 0) and a secondary bus master such as a DMA or UART loader (port 1). It selects one requester per cycle, drives the memory's address, write-data, read and write strobes, and returns registered read data to the winning port. Requesters may lock the memory for back-to-back bursts. The block sits between the datapath's memory stage and the data memory.

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-port data memory between the CPU (port 0) and a bus master (port 1).
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins every tie.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   tie_pick1;

`ifdef DMEM_ARB_RR_EN
    assign tie_pick1 = ~last;
`else
    // last is still tracked in fixed-priority builds but never steers a tie
    assign tie_pick1 = last & 1'b0;
`endif

    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (p0_req && p1_req) begin
                    p0_gnt = ~tie_pick1;
                    p1_gnt = tie_pick1;
                end else begin
                    p0_gnt = p0_req;
                    p1_gnt = p1_req;
                end
                if (p0_gnt && p0_lock) begin
                    state_nxt = OWN0;
                end else if (p1_gnt && p1_lock) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                p0_gnt = p0_req;
                if (!p0_lock) begin
                    state_nxt = IDLE;
                end
            end
            OWN1: begin
                p1_gnt = p1_req;
                if (!p1_lock) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (!reset_n) begin
            p0_gnt = 1'b0;
            p1_gnt = 1'b0;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (p0_gnt) begin
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_read  = ~p0_we;
            mem_write = p0_we;
        end else if (p1_gnt) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_read  = ~p1_we;
            mem_write = p1_we;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (p0_gnt) begin
                last <= 1'b0;
            end else if (p1_gnt) begin
                last <= 1'b1;
            end
        end
    end

    // Read data is captured at the edge closing the grant cycle, one-cycle rvalid follows
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt && !p0_we) begin
                p0_rdata <= mem_rdata;
            end
            if (p1_gnt && !p1_we) begin
                p1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level ownership model.
// Follows DMEM_ARB_RR_EN the same way the design does.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
    logic        p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] bench_mem [16];
    logic [31:0] model_mem [16];

    int          checks = 0;
    int          errors = 0;

    int          owner;
    bit          m_last;
    bit          m_rv0, m_rv1;
    logic [31:0] m_rd0, m_rd1;
    bit          rr_mode;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = bench_mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            bench_mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model
    task automatic applyStimulus(input bit rstn,
                                 input bit r0, input bit w0, input bit l0, input logic [31:0] a0, input logic [31:0] d0,
                                 input bit r1, input bit w1, input bit l1, input logic [31:0] a1, input logic [31:0] d1);
        int          win;
        bit          exp_we;
        logic [31:0] exp_addr, exp_wdata;
        @(negedge clk);
        reset_n = rstn;
        p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
        #1;
        if (!rstn) begin
            owner = -1; m_last = 1'b1;
            m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
        end
        win = -1;
        if (rstn) begin
            if (owner == -1) begin
                if (r0 && r1)  win = (rr_mode && !m_last) ? 1 : 0;
                else if (r0)   win = 0;
                else if (r1)   win = 1;
            end else if (owner == 0) begin
                win = r0 ? 0 : -1;
            end else begin
                win = r1 ? 1 : -1;
            end
        end
        exp_we    = (win == 0) ? w0 : w1;
        exp_addr  = (win == 0) ? a0 : (win == 1) ? a1 : 32'h0;
        exp_wdata = (win == 0) ? d0 : (win == 1) ? d1 : 32'h0;
        checkOutput("p0_gnt", 64'(p0_gnt), 64'(win == 0));
        checkOutput("p1_gnt", 64'(p1_gnt), 64'(win == 1));
        checkOutput("mem_read", 64'(mem_read), 64'(win >= 0 && !exp_we));
        checkOutput("mem_write", 64'(mem_write), 64'(win >= 0 && exp_we));
        checkOutput("mem_addr", 64'(mem_addr), 64'(exp_addr));
        checkOutput("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
        checkOutput("p0_rvalid", 64'(p0_rvalid), 64'(m_rv0));
        checkOutput("p1_rvalid", 64'(p1_rvalid), 64'(m_rv1));
        checkOutput("p0_rdata", 64'(p0_rdata), 64'(m_rd0));
        checkOutput("p1_rdata", 64'(p1_rdata), 64'(m_rd1));
        m_rv0 = (win == 0) && !w0;
        m_rv1 = (win == 1) && !w1;
        if (m_rv0) m_rd0 = model_mem[a0[5:2]];
        if (m_rv1) m_rd1 = model_mem[a1[5:2]];
        if (win >= 0 && exp_we) model_mem[exp_addr[5:2]] = exp_wdata;
        if (win >= 0) m_last = (win == 1);
        if (rstn) begin
            if (owner == -1) begin
                if (win == 0 && l0) owner = 0;
                else if (win == 1 && l1) owner = 1;
            end else if (owner == 0) begin
                if (!l0) owner = -1;
            end else begin
                if (!l1) owner = -1;
            end
        end
    endtask

    initial begin
`ifdef DMEM_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        owner = -1; m_last = 1'b1; m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
        for (int i = 0; i < 16; i++) begin
            bench_mem[i] = 32'h0101_0101 * i;
            model_mem[i] = 32'h0101_0101 * i;
        end

        // Reset held with both ports requesting
        applyStimulus(0, 1, 1, 0, 32'h4, 32'h11, 1, 1, 0, 32'h8, 32'h22);
        applyStimulus(0, 1, 1, 0, 32'h4, 32'h11, 1, 1, 0, 32'h8, 32'h22);

        // p1 write then read of the same word
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h10, 32'hDEADBEEF);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        checkOutput("p1_rdata_wr_rd", 64'(p1_rdata), 64'h0000_0000_DEAD_BEEF);
        checkOutput("p1_rvalid_wr_rd", 64'(p1_rvalid), 64'h1);

        // Continuous tie on reads
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 0, 0, 32'h20 + 4 * i, 0, 1, 0, 0, 32'h30 + 4 * i, 0);
        end

        // Locked burst from p1 while p0 waits
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1, 1, 1, 32'h14, 32'hA1);
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 1, 1, 1, 32'h18, 32'hA2);
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 1, 1, 0, 32'h1C, 32'hA3);
        applyStimulus(1, 1, 0, 0, 32'h14, 0, 0, 0, 0, 32'h0, 32'h0);
        checkOutput("p0_gnt_after_burst", 64'(p0_gnt), 64'h1);

        // Reset asserted in the middle of a locked p1 read burst
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1, 0, 1, 32'h18, 0);
        applyStimulus(0, 1, 0, 0, 32'h24, 0, 1, 0, 1, 32'h18, 0);
        checkOutput("p1_rvalid_mid_reset", 64'(p1_rvalid), 64'h0);
        applyStimulus(1, 1, 0, 0, 32'h24, 0, 0, 0, 0, 32'h0, 0);
        checkOutput("p0_gnt_after_reset", 64'(p0_gnt), 64'h1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);

        // Random traffic with occasional locks and resets
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 99) != 0,
                          1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, $urandom, $urandom,
                          1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
